// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared types and constants for the miniRV write-back arbiter
//               and register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    // Default architectural register count.
    localparam int NREGS_DEFAULT = 16;

    // Widest register index carried in a write-back request record.
    localparam int RD_MAX_W = 8;

    // Register-index width for a given register count (at least one bit).
    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int AW_DEFAULT = addr_width(NREGS_DEFAULT);

    // x0 is hard-wired to zero: writes to it are consumed but dropped.
    localparam logic [RD_MAX_W-1:0] REG_ZERO = '0;

    // One write-back request as seen after arbitration.
    typedef struct packed {
        logic [RD_MAX_W-1:0] rd;
        logic [31:0]         wdata;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : N-way round-robin arbiter. Search starts at the rotating
//               pointer; the pointer moves past the winner after each grant.
//               No grants while hold is high or while reset is asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic [N-1:0]  valid,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any_grant
);

    logic [PW-1:0] ptr;

    // Rotating priority search: first valid requester at or after ptr wins.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_grant && !hold && rst_n && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
                any_grant  = 1'b1;
            end
        end
    end

    // Pointer advances to the requester after the winner; held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (any_grant) begin
            if (int'(grant_idx) == N - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Write-back arbiter in front of the single register-file write
//               port, with a busy scoreboard of outstanding destinations for
//               RAW-hazard stalls in the issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter  int NREQ  = 2,
    parameter  int NREGS = NREGS_DEFAULT,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][AW-1:0]   req_rd,
    input  logic [NREQ-1:0][31:0]     req_wdata,
    input  logic                      alloc_valid,
    input  logic [AW-1:0]             alloc_rd,
    output logic [NREGS-1:0]          busy,
    output logic                      rf_we,
    output logic [AW-1:0]             rf_rd,
    output logic [31:0]               rf_wdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    grant_idx;
    logic             transfer;
    wb_req_t          sel;
    logic [NREGS-1:1] busy_set;
    logic [NREGS-1:1] busy_clr;
    logic [NREGS-1:1] busy_q;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .valid     (req_valid),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .any_grant (transfer)
    );

    // Pick the winning requester's destination and data.
    always_comb begin
        sel              = '0;
        sel.rd[AW-1:0]   = req_rd[grant_idx];
        sel.wdata        = req_wdata[grant_idx];
    end

    // Registered write port: x0 transfers are consumed but never written;
    // destination/data keep their last value when nothing transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= transfer && (sel.rd != REG_ZERO);
            if (transfer) begin
                rf_rd    <= sel.rd[AW-1:0];
                rf_wdata <= sel.wdata;
            end
        end
    end

    // Per-register set/clear decode; x0 has no entry so it can never be busy.
    generate
        for (genvar r = 1; r < NREGS; r++) begin : g_sb
            assign busy_set[r] = alloc_valid && (alloc_rd == AW'(r));
            assign busy_clr[r] = transfer && (sel.rd == RD_MAX_W'(r));
        end
    endgenerate

    // Scoreboard update: a same-cycle allocate overrides the clear, since the
    // new producer is still outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~busy_clr) | busy_set;
        end
    end

    assign busy = {busy_q, 1'b0};

endmodule
`default_nettype wire
